// File: rtl/fp_norm_pkg.sv
// Shared floating-point normaliser definitions: common widths and the
// constant clog2 helper used to size leading-zero counts.
package fp_norm_pkg;

  localparam int unsigned FP_MANT_W = 24;
  localparam int unsigned FP_EXP_W  = 8;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lzc_core.sv
// Combinational leading-zero counter; reports MANT_W for an all-zero input.
module lzc_core
  import fp_norm_pkg::*;
#(
  parameter  int unsigned MANT_W = FP_MANT_W,
  localparam int unsigned CNT_W  = clog2(MANT_W + 1)
) (
  input  logic [MANT_W-1:0] mant_i,
  output logic [CNT_W-1:0]  lz_o
);

  logic found;

  // Priority scan from the MSB; the first set bit fixes the count.
  always_comb begin
    lz_o  = CNT_W'(MANT_W);
    found = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found && mant_i[i]) begin
        lz_o  = CNT_W'(MANT_W - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lzc_normalizer_pipe.sv
// Two-stage mantissa normaliser: stage 1 counts leading zeros, stage 2 shifts
// the mantissa and adjusts the exponent, clamping denormals at exponent 0.
module lzc_normalizer_pipe
  import fp_norm_pkg::*;
#(
  parameter  int unsigned MANT_W = FP_MANT_W,
  parameter  int unsigned EXP_W  = FP_EXP_W,
  localparam int unsigned CNT_W  = clog2(MANT_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [CNT_W-1:0]  out_lz,
  output logic              out_zero,
  output logic              out_uflow
);

  localparam int unsigned CMP_W = (CNT_W > EXP_W) ? CNT_W : EXP_W;

  logic              s1_valid_q, s1_valid_d;
  logic [MANT_W-1:0] s1_mant_q,  s1_mant_d;
  logic [EXP_W-1:0]  s1_exp_q,   s1_exp_d;
  logic [CNT_W-1:0]  s1_lz_q,    s1_lz_d;
  logic              s2_valid_q, s2_valid_d;
  logic [MANT_W-1:0] mant_q,     mant_d;
  logic [EXP_W-1:0]  exp_q,      exp_d;
  logic [CNT_W-1:0]  lz_q,       lz_d;
  logic              zero_q,     zero_d;
  logic              uflow_q,    uflow_d;

  logic              s2_ready;
  logic              s1_load;
  logic              s2_load;
  logic [CNT_W-1:0]  lz_in;
  logic [CNT_W-1:0]  shift;

  lzc_core #(.MANT_W(MANT_W)) u_lzc (
    .mant_i (in_mant),
    .lz_o   (lz_in)
  );

  assign s2_ready = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s2_ready;

  // Stage 1: capture the beat and its leading-zero count on accept.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mant_d  = s1_mant_q;
    s1_exp_d   = s1_exp_q;
    s1_lz_d    = s1_lz_q;
    if (in_ready) s1_valid_d = in_valid;
    if (s1_load) begin
      s1_mant_d = in_mant;
      s1_exp_d  = in_exp;
      s1_lz_d   = lz_in;
    end
  end

  // Stage 2: shift by min(lz, exp) so the exponent never goes below zero.
  always_comb begin
    s2_valid_d = s2_valid_q;
    mant_d     = mant_q;
    exp_d      = exp_q;
    lz_d       = lz_q;
    zero_d     = zero_q;
    uflow_d    = uflow_q;
    shift      = '0;
    if (s2_ready) s2_valid_d = s1_valid_q;
    if (s2_load) begin
      lz_d = s1_lz_q;
      if (s1_mant_q == '0) begin
        mant_d  = '0;
        exp_d   = '0;
        zero_d  = 1'b1;
        uflow_d = 1'b0;
      end else if (CMP_W'(s1_lz_q) <= CMP_W'(s1_exp_q)) begin
        shift   = s1_lz_q;
        mant_d  = s1_mant_q << shift;
        exp_d   = EXP_W'(CMP_W'(s1_exp_q) - CMP_W'(s1_lz_q));
        zero_d  = 1'b0;
        uflow_d = 1'b0;
      end else begin
        shift   = CNT_W'(s1_exp_q);
        mant_d  = s1_mant_q << shift;
        exp_d   = '0;
        zero_d  = 1'b0;
        uflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_lz_q    <= '0;
      s2_valid_q <= 1'b0;
      mant_q     <= '0;
      exp_q      <= '0;
      lz_q       <= '0;
      zero_q     <= 1'b0;
      uflow_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mant_q  <= s1_mant_d;
      s1_exp_q   <= s1_exp_d;
      s1_lz_q    <= s1_lz_d;
      s2_valid_q <= s2_valid_d;
      mant_q     <= mant_d;
      exp_q      <= exp_d;
      lz_q       <= lz_d;
      zero_q     <= zero_d;
      uflow_q    <= uflow_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_mant  = mant_q;
  assign out_exp   = exp_q;
  assign out_lz    = lz_q;
  assign out_zero  = zero_q;
  assign out_uflow = uflow_q;

endmodule

// File: tb/tb_lzc_normalizer_pipe.sv
// Self-checking bench for lzc_normalizer_pipe: directed vector table,
// stall/reset sequences and randomized traffic against a scoreboard model.
module tb_lzc_normalizer_pipe;

  localparam int MW = 24;
  localparam int EW = 8;
  localparam int CW = 5;

  typedef struct packed {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic [CW-1:0] lz;
    logic          zero;
    logic          uflow;
  } res_t;

  typedef struct {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    res_t          res;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] in_mant = '0;
  logic [EW-1:0] in_exp = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic [CW-1:0] out_lz;
  logic          out_zero;
  logic          out_uflow;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  res_t prev_res;
  logic stalled = 1'b0;
  int   in_block_cnt = 0;
  int   out_beats = 0;
  logic rand_done = 1'b0;
  vec_t vecs[8];

  lzc_normalizer_pipe #(.MANT_W(MW), .EXP_W(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_lz    (out_lz),
    .out_zero  (out_zero),
    .out_uflow (out_uflow)
  );

  always #5 clk = ~clk;

  function automatic res_t cur_res();
    return '{out_mant, out_exp, out_lz, out_zero, out_uflow};
  endfunction

  // Reference: lz = width minus bit length; shift = min(lz, exp).
  function automatic res_t model(input logic [MW-1:0] m, input logic [EW-1:0] e);
    res_t   r;
    longint v;
    int     bl, lz, sh;
    v  = longint'(m);
    bl = 0;
    while (v > 0) begin
      v  = v / 2;
      bl = bl + 1;
    end
    lz = MW - bl;
    r.lz = CW'(lz);
    if (m == 0) begin
      r.mant = '0; r.exp = '0; r.zero = 1'b1; r.uflow = 1'b0;
    end else begin
      sh      = (lz <= int'(e)) ? lz : int'(e);
      r.mant  = MW'((longint'(m) * (longint'(1) << sh)) % (longint'(1) << MW));
      r.exp   = EW'(int'(e) - sh);
      r.zero  = 1'b0;
      r.uflow = (lz > int'(e));
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", 64'(cur_res()), 64'(prev_res));
      if (in_valid && in_ready) exp_q.push_back(model(in_mant, in_exp));
      if (in_valid && !in_ready) in_block_cnt++;
      if (out_valid && out_ready) begin
        out_beats++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", cur_res());
        end else begin
          check("scoreboard", 64'(cur_res()), 64'(exp_q.pop_front()));
        end
      end
      stalled  = out_valid && !out_ready;
      prev_res = cur_res();
    end
  end

  // Called and returning at posedge+1; holds the beat until accepted.
  task automatic send(input logic [MW-1:0] m, input logic [EW-1:0] e);
    logic acc;
    int   n;
    n = 0;
    in_valid = 1'b1; in_mant = m; in_exp = e;
    while (1) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 60) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stuck low, expected accept");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int   n;
    int   t0;
    res_t zr;
    zr = '0;

    vecs[0] = '{24'hF28D54, 8'd100, '{24'hF28D54, 8'd100, 5'd0,  1'b0, 1'b0}};
    vecs[1] = '{24'h000001, 8'd127, '{24'h800000, 8'd104, 5'd23, 1'b0, 1'b0}};
    vecs[2] = '{24'h000000, 8'd50,  '{24'h000000, 8'd0,   5'd24, 1'b1, 1'b0}};
    vecs[3] = '{24'h000010, 8'd5,   '{24'h000200, 8'd0,   5'd19, 1'b0, 1'b1}};
    vecs[4] = '{24'h000010, 8'd19,  '{24'h800000, 8'd0,   5'd19, 1'b0, 1'b0}};
    vecs[5] = '{24'h000100, 8'd15,  '{24'h800000, 8'd0,   5'd15, 1'b0, 1'b0}};
    vecs[6] = '{24'h400000, 8'd255, '{24'h800000, 8'd254, 5'd1,  1'b0, 1'b0}};
    vecs[7] = '{24'h000003, 8'd0,   '{24'h000003, 8'd0,   5'd22, 1'b0, 1'b1}};

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_ready",  64'(in_ready),  64'(1));
    check("reset_outputs",   64'(cur_res()), 64'(zr));

    // Directed table, one beat at a time with latency measured.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].mant, vecs[i].exp);
      n = 0;
      while (n < 10) begin
        @(negedge clk);
        n++;
        if (out_valid) break;
      end
      check($sformatf("latency_%0d", i), 64'(n), 64'(2));
      check($sformatf("vec_%0d", i), 64'(cur_res()), 64'(vecs[i].res));
      @(posedge clk); #1;
    end
    wait_drain();

    // Back-to-back stream into a stalled output.
    in_block_cnt = 0;
    out_ready = 1'b0;
    fork
      begin
        send(24'h00ABCD, 8'd3);
        send(24'h123456, 8'd200);
        send(24'h000000, 8'd9);
        send(24'h0000F0, 8'd40);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    check("stall_backpressure", 64'(in_block_cnt > 0), 64'(1));
    wait_drain();

    // Full rate: 16 beats in 16 cycles with no backpressure.
    in_block_cnt = 0;
    out_beats = 0;
    t0 = int'($time);
    for (int i = 0; i < 16; i++) send(24'(32'h1 << i), 8'(i * 3));
    check("full_rate_cycles", 64'((int'($time) - t0) / 10), 64'(16));
    check("full_rate_no_block", 64'(in_block_cnt), 64'(0));
    wait_drain();
    check("full_rate_beats", 64'(out_beats), 64'(16));

    // Reset with both stages full: beats must vanish.
    out_ready = 1'b0;
    send(24'h0F0F0F, 8'd77);
    send(24'h000777, 8'd12);
    check("pre_reset_full", 64'(in_ready), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_outputs",   64'(cur_res()), 64'(zr));
    out_ready = 1'b1;
    out_beats = 0;
    repeat (6) @(posedge clk);
    #1 check("no_stale_beat", 64'(out_beats), 64'(0));

    // Randomized traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [MW-1:0] m;
          logic [EW-1:0] e;
          m = MW'($urandom) >> $urandom_range(0, MW);
          e = ($urandom_range(0, 1) == 1) ? EW'($urandom_range(0, 30)) : EW'($urandom_range(0, 255));
          send(m, e);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
